// File: rtl/parity_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, parity bit, stop bit.
// Reports each completed frame with parity/framing flags and keeps a saturating error count.
module parity_rx #(
    parameter int DATA_W = 8,
    parameter int ODD    = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_valid,
    input  logic              rx_bit,
    input  logic              err_clr,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic [7:0]        err_count,
    output logic              busy
);

    localparam int            IW       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);
    localparam logic          P_ODD    = (ODD != 0);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t            r_state;
    logic [IW-1:0]     r_idx;
    logic [DATA_W-1:0] r_shift;
    logic              r_acc;
    logic              r_perr_pend;
    logic [DATA_W-1:0] r_data;
    logic              r_dv;
    logic              r_perr;
    logic              r_ferr;
    logic [7:0]        r_err_cnt;
    logic              w_frame_bad;

    // A frame counts as bad on the stop bit if the parity check failed or the stop bit is 0.
    assign w_frame_bad = r_perr_pend | ~rx_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_shift     <= '0;
            r_acc       <= 1'b0;
            r_perr_pend <= 1'b0;
            r_data      <= '0;
            r_dv        <= 1'b0;
            r_perr      <= 1'b0;
            r_ferr      <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_dv <= 1'b0;
            if (bit_valid) begin
                case (r_state)
                    IDLE: begin
                        if (!rx_bit) begin
                            r_state <= DATA;
                            r_idx   <= '0;
                            r_acc   <= 1'b0;
                        end
                    end
                    DATA: begin
                        r_shift[r_idx] <= rx_bit;
                        r_acc          <= r_acc ^ rx_bit;
                        if (r_idx == IDX_LAST) r_state <= PARITY;
                        else                   r_idx   <= r_idx + IW'(1);
                    end
                    PARITY: begin
                        r_perr_pend <= r_acc ^ rx_bit ^ P_ODD;
                        r_state     <= STOP;
                    end
                    STOP: begin
                        // A 0 stop bit is a framing error, never a fresh start bit.
                        r_state <= IDLE;
                        r_data  <= r_shift;
                        r_perr  <= r_perr_pend;
                        r_ferr  <= ~rx_bit;
                        r_dv    <= 1'b1;
                        if (w_frame_bad && r_err_cnt != 8'hFF)
                            r_err_cnt <= r_err_cnt + 8'd1;
                    end
                    default: r_state <= IDLE;
                endcase
            end
            if (err_clr) r_err_cnt <= '0;
        end
    end

    assign data_out   = r_data;
    assign data_valid = r_dv;
    assign parity_err = r_perr;
    assign frame_err  = r_ferr;
    assign err_count  = r_err_cnt;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_parity_rx.sv
// Directed bench for parity_rx: an even-parity and an odd-parity instance share one serial line.
module tb_parity_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bit_valid = 1'b0;
    logic       rx_bit = 1'b1;
    logic       err_clr = 1'b0;

    logic [7:0] data_out, data_out_o;
    logic       data_valid, data_valid_o;
    logic       parity_err, parity_err_o;
    logic       frame_err, frame_err_o;
    logic [7:0] err_count, err_count_o;
    logic       busy, busy_o;

    int n_cmp  = 0;
    int n_fail = 0;
    int dv_cnt = 0;

    always #5 clk = ~clk;

    parity_rx #(.DATA_W(8), .ODD(0)) dut (
        .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .rx_bit(rx_bit), .err_clr(err_clr),
        .data_out(data_out), .data_valid(data_valid), .parity_err(parity_err),
        .frame_err(frame_err), .err_count(err_count), .busy(busy)
    );

    parity_rx #(.DATA_W(8), .ODD(1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .rx_bit(rx_bit), .err_clr(err_clr),
        .data_out(data_out_o), .data_valid(data_valid_o), .parity_err(parity_err_o),
        .frame_err(frame_err_o), .err_count(err_count_o), .busy(busy_o)
    );

    always @(negedge clk) if (data_valid === 1'b1) dv_cnt++;

    // Drives one frame, each bit preceded by 0..gmax idle cycles; returns at the negedge
    // where data_valid should be high, with bit_valid already dropped.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                              input int gmax, input logic clr_on_stop);
        logic [10:0] bits;
        bits = {s, p, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            int g;
            g = (gmax > 0) ? int'($urandom_range(0, gmax)) : 0;
            repeat (g) begin
                bit_valid = 1'b0;
                @(negedge clk);
            end
            bit_valid = 1'b1;
            rx_bit    = bits[i];
            if (i == 10) err_clr = clr_on_stop;
            @(negedge clk);
        end
        bit_valid = 1'b0;
        rx_bit    = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (data_out !== 8'h00)  begin n_fail++; $display("FAIL reset_data_out got %h want 00", data_out); end
        n_cmp++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_data_valid got %b want 0", data_valid); end
        n_cmp++; if ({parity_err, frame_err} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b want 00", {parity_err, frame_err}); end
        n_cmp++; if (err_count !== 8'h00) begin n_fail++; $display("FAIL reset_err_count got %0d want 0", err_count); end
        n_cmp++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int c0;
        c0 = dv_cnt;
        send_frame(8'hA5, 1'b0, 1'b1, 0, 1'b0);
        #1;
        n_cmp++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL basic_dv got %b want 1", data_valid); end
        n_cmp++; if (data_out !== 8'hA5)  begin n_fail++; $display("FAIL basic_data got %h want a5", data_out); end
        n_cmp++; if ({parity_err, frame_err} !== 2'b00) begin n_fail++; $display("FAIL basic_flags got %b want 00", {parity_err, frame_err}); end
        n_cmp++; if (err_count !== 8'd0)  begin n_fail++; $display("FAIL basic_err_count got %0d want 0", err_count); end
        @(negedge clk); #1;
        n_cmp++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL basic_dv_drop got %b want 0", data_valid); end
        n_cmp++; if (dv_cnt - c0 !== 1)   begin n_fail++; $display("FAIL basic_pulses got %0d want 1", dv_cnt - c0); end
        n_cmp++; if (data_out !== 8'hA5)  begin n_fail++; $display("FAIL basic_hold got %h want a5", data_out); end
    endtask

    task automatic test_errors();
        send_frame(8'hA5, 1'b1, 1'b1, 0, 1'b0);
        #1;
        n_cmp++; if (parity_err !== 1'b1) begin n_fail++; $display("FAIL perr_flag got %b want 1", parity_err); end
        n_cmp++; if (frame_err !== 1'b0)  begin n_fail++; $display("FAIL perr_ferr got %b want 0", frame_err); end
        n_cmp++; if (data_out !== 8'hA5)  begin n_fail++; $display("FAIL perr_data got %h want a5", data_out); end
        n_cmp++; if (err_count !== 8'd1)  begin n_fail++; $display("FAIL perr_count got %0d want 1", err_count); end
        send_frame(8'h03, 1'b0, 1'b0, 0, 1'b0);
        #1;
        n_cmp++; if (frame_err !== 1'b1)  begin n_fail++; $display("FAIL ferr_flag got %b want 1", frame_err); end
        n_cmp++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL ferr_perr got %b want 0", parity_err); end
        n_cmp++; if (data_out !== 8'h03)  begin n_fail++; $display("FAIL ferr_data got %h want 03", data_out); end
        n_cmp++; if (err_count !== 8'd2)  begin n_fail++; $display("FAIL ferr_count got %0d want 2", err_count); end
        // The 0 stop bit must not have opened a new frame.
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL ferr_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_odd();
        send_frame(8'h00, 1'b1, 1'b1, 0, 1'b0);
        #1;
        n_cmp++; if (data_valid_o !== 1'b1) begin n_fail++; $display("FAIL odd_dv got %b want 1", data_valid_o); end
        n_cmp++; if (parity_err_o !== 1'b0) begin n_fail++; $display("FAIL odd_good_perr got %b want 0", parity_err_o); end
        n_cmp++; if (parity_err !== 1'b1)   begin n_fail++; $display("FAIL even_same_frame_perr got %b want 1", parity_err); end
        send_frame(8'h00, 1'b0, 1'b1, 0, 1'b0);
        #1;
        n_cmp++; if (parity_err_o !== 1'b1) begin n_fail++; $display("FAIL odd_bad_perr got %b want 1", parity_err_o); end
        n_cmp++; if (parity_err !== 1'b0)   begin n_fail++; $display("FAIL even_zero_perr got %b want 0", parity_err); end
    endtask

    task automatic test_back_to_back();
        int c0;
        logic [7:0] ec;
        @(negedge clk);
        c0 = dv_cnt;
        ec = err_count;
        send_frame(8'h3C, 1'b0, 1'b1, 5, 1'b0);
        #1;
        n_cmp++; if (data_out !== 8'h3C) begin n_fail++; $display("FAIL gaps_data1 got %h want 3c", data_out); end
        n_cmp++; if ({parity_err, frame_err} !== 2'b00) begin n_fail++; $display("FAIL gaps_flags1 got %b want 00", {parity_err, frame_err}); end
        // Start bit of the second frame is accepted while data_valid is high.
        send_frame(8'hC3, 1'b0, 1'b1, 0, 1'b0);
        #1;
        n_cmp++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_dv got %b want 1", data_valid); end
        n_cmp++; if (data_out !== 8'hC3)  begin n_fail++; $display("FAIL b2b_data2 got %h want c3", data_out); end
        n_cmp++; if ({parity_err, frame_err} !== 2'b00) begin n_fail++; $display("FAIL b2b_flags2 got %b want 00", {parity_err, frame_err}); end
        n_cmp++; if (dv_cnt - c0 !== 2)   begin n_fail++; $display("FAIL b2b_pulses got %0d want 2", dv_cnt - c0); end
        n_cmp++; if (err_count !== ec)    begin n_fail++; $display("FAIL b2b_err_count got %0d want %0d", err_count, ec); end
    endtask

    task automatic test_mid_reset();
        int c0;
        logic [4:0] part;
        part = 5'b11010;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            bit_valid = 1'b1;
            rx_bit    = part[i];
            @(negedge clk);
        end
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before got %b want 1", busy); end
        c0 = dv_cnt;
        rst_n     = 1'b0;
        bit_valid = 1'b0;
        rx_bit    = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy); end
        n_cmp++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL midrst_data got %h want 00", data_out); end
        n_cmp++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL midrst_count got %0d want 0", err_count); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(8'h5A, 1'b0, 1'b1, 0, 1'b0);
        #1;
        n_cmp++; if (data_out !== 8'h5A) begin n_fail++; $display("FAIL midrst_data2 got %h want 5a", data_out); end
        @(negedge clk); #1;
        n_cmp++; if (dv_cnt - c0 !== 1)  begin n_fail++; $display("FAIL midrst_pulses got %0d want 1", dv_cnt - c0); end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 255; i++) send_frame(8'h00, 1'b1, 1'b1, 0, 1'b0);
        #1;
        n_cmp++; if (err_count !== 8'd255) begin n_fail++; $display("FAIL sat_255 got %0d want 255", err_count); end
        send_frame(8'h00, 1'b1, 1'b1, 0, 1'b0);
        #1;
        n_cmp++; if (err_count !== 8'd255) begin n_fail++; $display("FAIL sat_256 got %0d want 255", err_count); end
        // Clear held across the stop bit edge and the data_valid cycle of an error frame.
        send_frame(8'h00, 1'b1, 1'b1, 0, 1'b1);
        #1;
        n_cmp++; if (data_valid !== 1'b1)  begin n_fail++; $display("FAIL clr_dv got %b want 1", data_valid); end
        n_cmp++; if (err_count !== 8'd0)   begin n_fail++; $display("FAIL clr_wins got %0d want 0", err_count); end
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        n_cmp++; if (err_count !== 8'd0)   begin n_fail++; $display("FAIL clr_after got %0d want 0", err_count); end
        send_frame(8'h01, 1'b0, 1'b1, 0, 1'b0);
        #1;
        n_cmp++; if (err_count !== 8'd1)   begin n_fail++; $display("FAIL clr_recount got %0d want 1", err_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_errors();
        test_odd();
        test_back_to_back();
        test_mid_reset();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
